// File: rtl/icache_axi_refill_if.sv
// Bus bundle between the ICache refill port, this responder and the AXI instruction read port.
// slave = the refill engine's view, master = the ICache/memory side driving it.
interface icache_axi_refill_if;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         ret_valid;
  logic [255:0] ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  modport slave (
    input  rd_req, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
    output ret_valid, ret_data, arid, araddr, arlen, arsize, arburst, arvalid, rready
  );

  modport master (
    output rd_req, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
    input  ret_valid, ret_data, arid, araddr, arlen, arsize, arburst, arvalid, rready
  );
endinterface

// File: rtl/icache_axi_refill.sv
// ICache miss responder: one 8-beat AXI4 read burst per refill, returned as a 256-bit line.
// Define ICACHE_REFILL_CRITICAL_WORD_FIRST_EN for a WRAP burst starting at the missed word.
module icache_axi_refill #(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         LINE_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  icache_axi_refill_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t                    r_state, w_state_next;
  logic [31:0]               r_araddr, w_araddr_next;
  logic [2:0]                r_cnt, w_cnt_next;
  logic [2:0]                r_start_word, w_start_word_next;
  logic [32*LINE_WORDS-1:0]  r_ret_data, w_ret_data_next;
  logic                      r_arvalid, r_rready, r_ret_valid;

  logic [31:0] w_line_addr;
  logic [2:0]  w_req_start;
  logic [1:0]  w_arburst;
  logic        w_beat;
  logic [2:0]  w_idx;
  logic        w_unused;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign w_line_addr = {bus.rd_addr[31:2], 2'b00};
  assign w_req_start = bus.rd_addr[4:2];
  assign w_arburst   = 2'b10;
`else
  assign w_line_addr = {bus.rd_addr[31:5], 5'b00000};
  assign w_req_start = 3'd0;
  assign w_arburst   = 2'b01;
`endif

  // Foreign-ID beats are accepted (rready high) but never stored or counted.
  assign w_beat   = bus.rvalid && (bus.rid == AXI_ID);
  assign w_idx    = r_start_word + r_cnt;
  assign w_unused = ^{bus.rresp, bus.rd_addr[4:0]};

  always_comb begin
    w_state_next      = r_state;
    w_araddr_next     = r_araddr;
    w_cnt_next        = r_cnt;
    w_start_word_next = r_start_word;
    w_ret_data_next   = r_ret_data;
    unique case (r_state)
      S_IDLE: begin
        if (bus.rd_req) begin
          w_state_next      = S_AR;
          w_araddr_next     = w_line_addr;
          w_start_word_next = w_req_start;
          w_cnt_next        = 3'd0;
        end
      end
      S_AR: begin
        if (r_arvalid && bus.arready) begin
          w_state_next = S_R;
        end
      end
      S_R: begin
        // rlast ends the burst regardless of how many beats were counted.
        if (w_beat) begin
          w_ret_data_next[{w_idx, 5'b00000} +: 32] = bus.rdata;
          w_cnt_next = r_cnt + 3'd1;
          if (bus.rlast) begin
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_araddr     <= '0;
      r_cnt        <= '0;
      r_start_word <= '0;
      r_ret_data   <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_ret_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_araddr     <= w_araddr_next;
      r_cnt        <= w_cnt_next;
      r_start_word <= w_start_word_next;
      r_ret_data   <= w_ret_data_next;
      r_arvalid    <= (w_state_next == S_AR);
      r_rready     <= (w_state_next == S_R);
      r_ret_valid  <= (w_state_next == S_DONE);
    end
  end

  assign bus.arid      = AXI_ID;
  assign bus.araddr    = r_araddr;
  assign bus.arlen     = 8'd7;
  assign bus.arsize    = 3'b010;
  assign bus.arburst   = w_arburst;
  assign bus.arvalid   = r_arvalid;
  assign bus.rready    = r_rready;
  assign bus.ret_valid = r_ret_valid;
  assign bus.ret_data  = r_ret_data;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Directed bench for icache_axi_refill: latency, AR backpressure, gapped/foreign R beats,
// back-to-back refills, mid-burst reset, and the critical-word-first address/ordering.
module tb_icache_axi_refill;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  localparam bit Cwf = 1'b1;
`else
  localparam bit Cwf = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  icache_axi_refill_if bus();

  icache_axi_refill #(.AXI_ID(4'd0), .LINE_WORDS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expAraddr(input logic [31:0] a);
    return Cwf ? {a[31:2], 2'b00} : {a[31:5], 5'b00000};
  endfunction

  function automatic logic [2:0] expStart(input logic [31:0] a);
    return Cwf ? a[4:2] : 3'd0;
  endfunction

  // Beat i carries base+i and lands in word (startWord+i) mod 8.
  function automatic logic [255:0] expLine(input logic [31:0] base, input logic [2:0] startWord);
    logic [255:0] l;
    logic [2:0]   w;
    l = '0;
    for (int i = 0; i < 8; i++) begin
      w = startWord + 3'(i);
      l[{w, 5'b00000} +: 32] = base + 32'(i);
    end
    return l;
  endfunction

  // Issue a one-cycle rd_req and step into the AR state.
  task automatic applyStimulus(input logic [31:0] addr, input bit holdReq);
    bus.rd_addr = addr;
    bus.rd_req  = 1'b1;
    stepCycle();
    if (!holdReq) bus.rd_req = 1'b0;
  endtask

  task automatic sendBeats(input logic [31:0] base, input bit gapped, input int foreignAt,
                           input int nBeats, input int lastIdx);
    int i = 0;
    bit gap = 1'b0;
    bit foreignDone = 1'b0;
    while (i < nBeats) begin
      bus.rvalid = 1'b1;
      bus.rid    = 4'd0;
      bus.rlast  = 1'b0;
      bus.rdata  = 32'd0;
      if (gap) begin
        bus.rvalid = 1'b0;
      end else if (i == foreignAt && !foreignDone) begin
        bus.rid     = 4'd1;
        bus.rdata   = 32'hDEAD_BEEF;
        bus.rlast   = 1'b1;
        foreignDone = 1'b1;
      end else begin
        bus.rdata = base + 32'(i);
        bus.rlast = (i == lastIdx);
        i++;
      end
      gap = gapped && !gap;
      stepCycle();
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rid    = 4'd0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n       = 1'b0;
    bus.rd_req  = 1'b0;
    bus.rd_addr = 32'd0;
    bus.arready = 1'b0;
    bus.rid     = 4'd0;
    bus.rdata   = 32'd0;
    bus.rresp   = 2'd0;
    bus.rlast   = 1'b0;
    bus.rvalid  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_arvalid",   bus.arvalid,   1'b0);
    checkOutput("rst_rready",    bus.rready,    1'b0);
    checkOutput("rst_ret_valid", bus.ret_valid, 1'b0);
    checkOutput("rst_araddr",    bus.araddr,    32'd0);
    checkOutput("rst_ret_data",  bus.ret_data,  256'd0);
    rst_n = 1'b1;
    stepCycle();

    // Test 1: basic refill, minimum latency
    $display("[TB] test 1 basic");
    bus.arready = 1'b1;
    applyStimulus(32'h1C00_0044, 1'b0);
    checkOutput("t1_arvalid", bus.arvalid, 1'b1);
    checkOutput("t1_araddr",  bus.araddr,  expAraddr(32'h1C00_0044));
    checkOutput("t1_arlen",   bus.arlen,   8'd7);
    checkOutput("t1_arsize",  bus.arsize,  3'b010);
    checkOutput("t1_arburst", bus.arburst, Cwf ? 2'b10 : 2'b01);
    checkOutput("t1_arid",    bus.arid,    4'd0);
    stepCycle();
    checkOutput("t1_rready",      bus.rready,  1'b1);
    checkOutput("t1_arvalid_low", bus.arvalid, 1'b0);
    sendBeats(32'h100, 1'b0, -1, 8, 7);
    checkOutput("t1_ret_valid", bus.ret_valid, 1'b1);
    checkOutput("t1_rready_low", bus.rready,   1'b0);
    checkOutput("t1_line", bus.ret_data, expLine(32'h100, expStart(32'h1C00_0044)));
`ifndef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    checkOutput("t1_line_lit", bus.ret_data,
                {32'h107, 32'h106, 32'h105, 32'h104, 32'h103, 32'h102, 32'h101, 32'h100});
`endif
    stepCycle();
    checkOutput("t1_pulse_end", bus.ret_valid, 1'b0);

    // Test 2: AR backpressure with premature R beats
    $display("[TB] test 2 AR backpressure");
    bus.arready = 1'b0;
    applyStimulus(32'h0000_1234, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.rvalid = 1'b1;
      bus.rid    = 4'd0;
      bus.rdata  = 32'h0000_0BAD;
      bus.rlast  = 1'b1;
      checkOutput("t2_arvalid", bus.arvalid, 1'b1);
      checkOutput("t2_araddr",  bus.araddr,  expAraddr(32'h0000_1234));
      checkOutput("t2_rready",  bus.rready,  1'b0);
      stepCycle();
    end
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    bus.arready = 1'b1;
    checkOutput("t2_arvalid_hold", bus.arvalid, 1'b1);
    stepCycle();
    checkOutput("t2_rready",    bus.rready,   1'b1);
    checkOutput("t2_line_kept", bus.ret_data, expLine(32'h100, expStart(32'h1C00_0044)));
    sendBeats(32'h300, 1'b0, -1, 8, 7);
    checkOutput("t2_ret_valid", bus.ret_valid, 1'b1);
    checkOutput("t2_line", bus.ret_data, expLine(32'h300, expStart(32'h0000_1234)));
    stepCycle();

    // Test 3: gapped R with a foreign-ID beat carrying rlast
    $display("[TB] test 3 gapped and foreign id");
    applyStimulus(32'h1C00_0044, 1'b0);
    checkOutput("t3_arvalid", bus.arvalid, 1'b1);
    stepCycle();
    sendBeats(32'h100, 1'b1, 3, 8, 7);
    checkOutput("t3_ret_valid", bus.ret_valid, 1'b1);
    checkOutput("t3_line", bus.ret_data, expLine(32'h100, expStart(32'h1C00_0044)));
    stepCycle();
    checkOutput("t3_pulse_end", bus.ret_valid, 1'b0);
    stepCycle();
    checkOutput("t3_no_repeat", bus.ret_valid, 1'b0);

    // Test 4: back-to-back with rd_req held across ret_valid
    $display("[TB] test 4 back-to-back");
    applyStimulus(32'h1C00_0044, 1'b1);
    checkOutput("t4_arvalid_a", bus.arvalid, 1'b1);
    stepCycle();
    sendBeats(32'h400, 1'b0, -1, 8, 7);
    checkOutput("t4_ret_valid_a", bus.ret_valid, 1'b1);
    checkOutput("t4_line_a", bus.ret_data, expLine(32'h400, expStart(32'h1C00_0044)));
    bus.rd_addr = 32'h1C00_0080;
    stepCycle();
    checkOutput("t4_idle_arvalid", bus.arvalid,   1'b0);
    checkOutput("t4_idle_ret",     bus.ret_valid, 1'b0);
    stepCycle();
    bus.rd_req = 1'b0;
    checkOutput("t4_arvalid_b", bus.arvalid, 1'b1);
    checkOutput("t4_araddr_b",  bus.araddr,  32'h1C00_0080);
    stepCycle();
    sendBeats(32'h500, 1'b0, -1, 8, 7);
    checkOutput("t4_ret_valid_b", bus.ret_valid, 1'b1);
    checkOutput("t4_line_b", bus.ret_data, expLine(32'h500, 3'd0));
    stepCycle();
    stepCycle();
    checkOutput("t4_quiet", bus.arvalid, 1'b0);

    // Test 5: reset after beat 3
    $display("[TB] test 5 reset mid-burst");
    applyStimulus(32'h1C00_0044, 1'b0);
    stepCycle();
    sendBeats(32'h600, 1'b0, -1, 4, 7);
    checkOutput("t5_in_r", bus.rready, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_arvalid",   bus.arvalid,   1'b0);
    checkOutput("t5_rready",    bus.rready,    1'b0);
    checkOutput("t5_ret_valid", bus.ret_valid, 1'b0);
    checkOutput("t5_araddr",    bus.araddr,    32'd0);
    checkOutput("t5_ret_data",  bus.ret_data,  256'd0);
    #3;
    rst_n = 1'b1;
    stepCycle();
    applyStimulus(32'h1C00_00C0, 1'b0);
    checkOutput("t5_arvalid_new", bus.arvalid, 1'b1);
    checkOutput("t5_araddr_new",  bus.araddr,  32'h1C00_00C0);
    stepCycle();
    sendBeats(32'h700, 1'b0, -1, 8, 7);
    checkOutput("t5_ret_valid_new", bus.ret_valid, 1'b1);
    checkOutput("t5_line_new", bus.ret_data, expLine(32'h700, 3'd0));
    stepCycle();

    // Test 6: address 0x1C000054, word order depends on the build
    $display("[TB] test 6 critical word address");
    applyStimulus(32'h1C00_0054, 1'b0);
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    checkOutput("t6_araddr",  bus.araddr,  32'h1C00_0054);
    checkOutput("t6_arburst", bus.arburst, 2'b10);
`else
    checkOutput("t6_araddr",  bus.araddr,  32'h1C00_0040);
    checkOutput("t6_arburst", bus.arburst, 2'b01);
`endif
    stepCycle();
    sendBeats(32'h200, 1'b0, -1, 8, 7);
    checkOutput("t6_ret_valid", bus.ret_valid, 1'b1);
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    checkOutput("t6_line", bus.ret_data,
                {32'h202, 32'h201, 32'h200, 32'h207, 32'h206, 32'h205, 32'h204, 32'h203});
`else
    checkOutput("t6_line", bus.ret_data,
                {32'h207, 32'h206, 32'h205, 32'h204, 32'h203, 32'h202, 32'h201, 32'h200});
`endif
    stepCycle();
    checkOutput("t6_pulse_end", bus.ret_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
